// File: rtl/rgb_encoder_input_if.sv
// Interface bundling the raw encoder pads with the decoded level outputs
// of one rgb_encoder_input channel.
//   master : the side that owns the pads and consumes the level
//   slave  : the encoder-input stage itself
interface rgb_encoder_input_if #(
   parameter int WIDTH = 8
);
   logic             enc_a;
   logic             enc_b;
   logic [WIDTH-1:0] value;
   logic             step_valid;
   logic             step_dir;

   modport master (
      output enc_a,
      output enc_b,
      input  value,
      input  step_valid,
      input  step_dir
   );

   modport slave (
      input  enc_a,
      input  enc_b,
      output value,
      output step_valid,
      output step_dir
   );
endinterface

// File: rtl/rgb_encoder_input.sv
// rgb_encoder_input: input-conditioning stage in front of one RGB mixer PWM
// channel. Synchronises and debounces a rotary-encoder A/B pair, decodes one
// detent per debounced rising edge of A, and keeps a WIDTH-bit level.
// Optional build macro: ENC_SATURATE_EN (clamp the level instead of wrapping).
module rgb_encoder_input #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int STEP            = 1,
   parameter int RESET_VALUE     = 0
) (
   input logic                clk,
   input logic                reset,
   rgb_encoder_input_if.slave bus
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int ARM_W = $clog2(DEBOUNCE_CYCLES + 4);
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [ARM_W-1:0] ARM_MAX     = ARM_W'(DEBOUNCE_CYCLES + 3);
   localparam logic [WIDTH-1:0] RESET_LEVEL = WIDTH'(RESET_VALUE);
`ifdef ENC_SATURATE_EN
   localparam logic [WIDTH:0]   STEP_EXT    = (WIDTH+1)'(STEP);
`else
   localparam logic [WIDTH-1:0] STEP_W      = WIDTH'(STEP);
`endif

   // Index 0 is line A, index 1 is line B.
   logic [1:0]       sync_s1;
   logic [1:0]       sync_s2;
   logic [1:0]       db;
   logic [CNT_W-1:0] cnt [2];
   logic             a_prev;
   logic [ARM_W-1:0] arm_cnt;
   logic             armed;
   logic             rise;
   logic             fire;
   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] value_next;
   logic             step_valid_q;
   logic             step_dir_q;
`ifdef ENC_SATURATE_EN
   logic [WIDTH:0]   up_sum;
   logic [WIDTH:0]   dn_diff;
`endif

   // Two-flop synchroniser; the only place the raw pads are read.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_s1 <= 2'b00;
         sync_s2 <= 2'b00;
      end else begin
         sync_s1 <= {bus.enc_b, bus.enc_a};
         sync_s2 <= sync_s1;
      end
   end

   // Per-line debounce: a line only changes after DEBOUNCE_CYCLES stable mismatching cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         db     <= 2'b00;
         cnt[0] <= '0;
         cnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync_s2[i] != db[i]) begin
               if (cnt[i] == CNT_LAST) begin
                  db[i]  <= sync_s2[i];
                  cnt[i] <= '0;
               end else begin
                  cnt[i] <= cnt[i] + CNT_W'(1);
               end
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end

   // Previous debounced A, for rising-edge detection.
   always_ff @(posedge clk) begin
      if (reset) a_prev <= 1'b0;
      else       a_prev <= db[0];
   end

   // Arm counter: blocks the spurious rise seen when a pad is already high at reset release.
   always_ff @(posedge clk) begin
      if (reset)                 arm_cnt <= '0;
      else if (arm_cnt != ARM_MAX) arm_cnt <= arm_cnt + ARM_W'(1);
   end

   assign armed = (arm_cnt == ARM_MAX);
   assign rise  = db[0] & ~a_prev;
   assign fire  = rise & armed;

   // Next level for a detent; B low means clockwise (up), B high means down.
   always_comb begin
      value_next = value_q;
`ifdef ENC_SATURATE_EN
      up_sum  = {1'b0, value_q} + STEP_EXT;
      dn_diff = {1'b0, value_q} - STEP_EXT;
      if (!db[1]) value_next = up_sum[WIDTH]  ? '1 : up_sum[WIDTH-1:0];
      else        value_next = dn_diff[WIDTH] ? '0 : dn_diff[WIDTH-1:0];
`else
      if (!db[1]) value_next = value_q + STEP_W;
      else        value_next = value_q - STEP_W;
`endif
   end

   // Output registers: level, one-cycle detent pulse and last direction.
   always_ff @(posedge clk) begin
      if (reset) begin
         value_q      <= RESET_LEVEL;
         step_valid_q <= 1'b0;
         step_dir_q   <= 1'b0;
      end else begin
         step_valid_q <= 1'b0;
         if (fire) begin
            value_q      <= value_next;
            step_valid_q <= 1'b1;
            step_dir_q   <= ~db[1];
         end
      end
   end

   assign bus.value      = value_q;
   assign bus.step_valid = step_valid_q;
   assign bus.step_dir   = step_dir_q;

endmodule

// File: tb/tb_rgb_encoder_input.sv
// Directed testbench for rgb_encoder_input at default parameters.
// Build with ENC_SATURATE_EN defined to exercise the clamping variant.
module tb_rgb_encoder_input;

   logic clk;
   logic reset;
   int   checks_total;
   int   checks_failed;
   int   pulse_cnt;
   int   pc0;

   rgb_encoder_input_if #(.WIDTH(8)) bus ();

   rgb_encoder_input #(
      .WIDTH(8), .DEBOUNCE_CYCLES(4), .STEP(1), .RESET_VALUE(0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

`ifdef ENC_SATURATE_EN
   localparam logic [31:0] EXP_BELOW_ZERO = 32'd0;
   localparam logic [31:0] EXP_ABOVE_MAX  = 32'd255;
`else
   localparam logic [31:0] EXP_BELOW_ZERO = 32'd255;
   localparam logic [31:0] EXP_ABOVE_MAX  = 32'd0;
`endif

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count detent pulses, sampled mid-cycle
   always @(negedge clk) begin
      if (bus.step_valid === 1'b1) pulse_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic a, input logic b);
      bus.enc_a = a;
      bus.enc_b = b;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks_total++;
      assert (observed === expected)
      else begin
         checks_failed++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic detent(input logic b);
      applyStimulus(1'b0, b);
      tick(8);
      applyStimulus(1'b1, b);
      tick(10);
      applyStimulus(1'b0, b);
      tick(8);
   endtask

   initial begin
      checks_total  = 0;
      checks_failed = 0;
      pulse_cnt     = 0;
      reset         = 1'b1;
      applyStimulus(1'b0, 1'b0);

      // 1. reset state
      tick(3);
      checkOutput("t1_value", 32'(bus.value), 32'd0);
      checkOutput("t1_step_valid", 32'(bus.step_valid), 32'd0);
      checkOutput("t1_step_dir", 32'(bus.step_dir), 32'd0);
      reset = 1'b0;
      tick(10);

      // 2. clockwise detent with 7-edge latency, then falling A
      pc0 = pulse_cnt;
      applyStimulus(1'b1, 1'b0);
      tick(6);
      checkOutput("t2_value_edge6", 32'(bus.value), 32'd0);
      checkOutput("t2_valid_edge6", 32'(bus.step_valid), 32'd0);
      tick(1);
      checkOutput("t2_value_edge7", 32'(bus.value), 32'd1);
      checkOutput("t2_valid_edge7", 32'(bus.step_valid), 32'd1);
      checkOutput("t2_dir_edge7", 32'(bus.step_dir), 32'd1);
      tick(1);
      checkOutput("t2_valid_edge8", 32'(bus.step_valid), 32'd0);
      tick(4);
      checkOutput("t2_pulses", 32'(pulse_cnt - pc0), 32'd1);
      applyStimulus(1'b0, 1'b0);
      tick(12);
      checkOutput("t2_fall_value", 32'(bus.value), 32'd1);
      checkOutput("t2_fall_pulses", 32'(pulse_cnt - pc0), 32'd1);

      // 3. three-cycle glitch on A
      pc0 = pulse_cnt;
      applyStimulus(1'b1, 1'b0);
      tick(3);
      applyStimulus(1'b0, 1'b0);
      tick(12);
      checkOutput("t3_value", 32'(bus.value), 32'd1);
      checkOutput("t3_pulses", 32'(pulse_cnt - pc0), 32'd0);

      // 4. chatter every 2 cycles, then settle high
      pc0 = pulse_cnt;
      for (int i = 0; i < 10; i++) begin
         applyStimulus((i % 2) == 0, 1'b0);
         tick(2);
      end
      applyStimulus(1'b1, 1'b0);
      tick(12);
      checkOutput("t4_pulses", 32'(pulse_cnt - pc0), 32'd1);
      checkOutput("t4_value", 32'(bus.value), 32'd2);
      applyStimulus(1'b0, 1'b0);
      tick(10);

      // 5a. step down through zero
      detent(1'b1);
      detent(1'b1);
      checkOutput("t5_at_zero", 32'(bus.value), 32'd0);
      checkOutput("t5_dir_down", 32'(bus.step_dir), 32'd0);
      applyStimulus(1'b0, 1'b1);
      tick(8);
      applyStimulus(1'b1, 1'b1);
      tick(7);
      checkOutput("t5_below_zero_value", 32'(bus.value), EXP_BELOW_ZERO);
      checkOutput("t5_below_zero_valid", 32'(bus.step_valid), 32'd1);
      checkOutput("t5_below_zero_dir", 32'(bus.step_dir), 32'd0);
      tick(4);
      applyStimulus(1'b0, 1'b1);
      tick(10);

      // 5b. step up through the maximum
`ifdef ENC_SATURATE_EN
      repeat (255) detent(1'b0);
`endif
      checkOutput("t5_at_max", 32'(bus.value), 32'd255);
      applyStimulus(1'b0, 1'b0);
      tick(8);
      applyStimulus(1'b1, 1'b0);
      tick(7);
      checkOutput("t5_above_max_value", 32'(bus.value), EXP_ABOVE_MAX);
      checkOutput("t5_above_max_valid", 32'(bus.step_valid), 32'd1);
      checkOutput("t5_above_max_dir", 32'(bus.step_dir), 32'd1);
      tick(4);
      applyStimulus(1'b0, 1'b0);
      tick(10);

      // 6a. A high through reset and after release: no step
      pc0 = pulse_cnt;
      applyStimulus(1'b1, 1'b0);
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(20);
      checkOutput("t6_held_value", 32'(bus.value), 32'd0);
      checkOutput("t6_held_dir", 32'(bus.step_dir), 32'd0);
      checkOutput("t6_held_pulses", 32'(pulse_cnt - pc0), 32'd0);

      // 6b. reset pulse during an in-flight debounce count
      applyStimulus(1'b0, 1'b0);
      tick(10);
      pc0 = pulse_cnt;
      applyStimulus(1'b1, 1'b0);
      tick(4);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(20);
      checkOutput("t6_pulse_value", 32'(bus.value), 32'd0);
      checkOutput("t6_pulse_pulses", 32'(pulse_cnt - pc0), 32'd0);

      // 6c. normal detent after recovery
      applyStimulus(1'b0, 1'b0);
      tick(10);
      applyStimulus(1'b1, 1'b0);
      tick(7);
      checkOutput("t6_recover_value", 32'(bus.value), 32'd1);
      checkOutput("t6_recover_valid", 32'(bus.step_valid), 32'd1);

      $display("%0d/%0d checks passed", checks_total - checks_failed, checks_total);
      $finish;
   end

endmodule
